// File: rtl/pkt_state_raw.sv
// pkt_state_raw: 2-cycle read-add-write state stage with same-index forwarding (optional RAW_SAT_EN saturating add)
module pkt_state_raw #(
  parameter int COUNT_WIDTH = 3,
  parameter int IDX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i__valid,
  input  logic [IDX_WIDTH-1:0]   i__idx,
  input  logic [1:0]             i__op,
  input  logic [COUNT_WIDTH-1:0] i__write_val,
  input  logic                   i__clear,
  output logic                   o__valid,
  output logic [COUNT_WIDTH-1:0] o__old_val,
`ifdef RAW_SAT_EN
  output logic                   o__sat,
`endif
  output logic [COUNT_WIDTH-1:0] o__new_val
);
  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  logic [COUNT_WIDTH-1:0] mem [DEPTH];
  logic v1, clr_d, commit, sat2;
  logic [IDX_WIDTH-1:0] idx1;
  logic [1:0] op1;
  logic [COUNT_WIDTH-1:0] wv1, old1, old_in, new2, addv;
`ifdef RAW_SAT_EN
  logic [COUNT_WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, old1} + {1'b0, wv1};
    sat2 = (op1 == OP_ADD) && sum[COUNT_WIDTH];
    addv = sat2 ? '1 : sum[COUNT_WIDTH-1:0];
  end
`else
  always_comb begin
    sat2 = 1'b0;
    addv = old1 + wv1;
  end
`endif
  // the cycle after a clear the stage-2 packet still holds pre-clear data, so it must not forward
  always_comb begin
    new2 = (op1 == OP_WR) ? wv1 : (op1 == OP_ADD) ? addv : old1;
    commit = v1 && ((op1 == OP_WR) || (op1 == OP_ADD));
    old_in = (v1 && (idx1 == i__idx) && !clr_d) ? new2 : mem[i__idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i__clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx1] <= new2;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      clr_d <= 1'b0;
      idx1 <= '0;
      op1 <= '0;
      wv1 <= '0;
      old1 <= '0;
      o__valid <= 1'b0;
      o__old_val <= '0;
      o__new_val <= '0;
    end else begin
      v1 <= i__valid;
      clr_d <= i__clear;
      if (i__valid) begin
        idx1 <= i__idx;
        op1 <= i__op;
        wv1 <= i__write_val;
        old1 <= old_in;
      end
      o__valid <= v1;
      if (v1) begin
        o__old_val <= old1;
        o__new_val <= new2;
      end
    end
  end
`ifdef RAW_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o__sat <= 1'b0;
    else o__sat <= v1 && sat2;
  end
`endif
endmodule

// File: tb/tb_pkt_state_raw.sv
// tb_pkt_state_raw: transaction-level model compared every cycle, plus directed literal checks
module tb_pkt_state_raw;
  logic clk = 1'b0;
  logic rst;
  logic i__valid;
  logic [1:0] i__idx;
  logic [1:0] i__op;
  logic [2:0] i__write_val;
  logic i__clear;
  logic o__valid;
  logic [2:0] o__old_val, o__new_val;
`ifdef RAW_SAT_EN
  logic o__sat;
`endif
  int n_chk = 0;
  int n_fail = 0;
  pkt_state_raw #(.COUNT_WIDTH(3), .IDX_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .i__valid(i__valid), .i__idx(i__idx), .i__op(i__op),
    .i__write_val(i__write_val), .i__clear(i__clear), .o__valid(o__valid),
    .o__old_val(o__old_val),
`ifdef RAW_SAT_EN
    .o__sat(o__sat),
`endif
    .o__new_val(o__new_val)
  );
  always #5 clk = ~clk;
  int m_mem [4];
  int p_v, p_idx, p_old, p_new, p_wr, p_sat, clr_prev;
  int e_v, e_old, e_new, e_sat;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 0;
    p_v = 0; p_idx = 0; p_old = 0; p_new = 0; p_wr = 0; p_sat = 0; clr_prev = 0;
    e_v = 0; e_old = 0; e_new = 0; e_sat = 0;
  endtask
  // each packet's result is fixed when it enters; its write lands one cycle later
  task automatic model_step();
    int old, nw, sat;
    if (rst) begin
      model_reset();
      return;
    end
    e_v = p_v;
    e_sat = p_v & p_sat;
    if (p_v != 0) begin
      e_old = p_old;
      e_new = p_new;
    end
    old = 0; nw = 0; sat = 0;
    if (i__valid) begin
      old = (p_v != 0 && p_idx == int'(i__idx) && clr_prev == 0) ? p_new : m_mem[i__idx];
      if (i__op == 2'd1) nw = int'(i__write_val);
      else if (i__op == 2'd2) begin
        nw = old + int'(i__write_val);
`ifdef RAW_SAT_EN
        if (nw > 7) begin
          nw = 7;
          sat = 1;
        end
`else
        nw = nw % 8;
`endif
      end else nw = old;
    end
    if (i__clear) for (int i = 0; i < 4; i++) m_mem[i] = 0;
    else if (p_v != 0 && p_wr != 0) m_mem[p_idx] = p_new;
    clr_prev = int'(i__clear);
    p_v = int'(i__valid);
    p_idx = int'(i__idx);
    p_old = old;
    p_new = nw;
    p_sat = sat;
    p_wr = (i__op == 2'd1 || i__op == 2'd2) ? 1 : 0;
  endtask
  always @(negedge clk) begin
    chk("valid", int'(o__valid), e_v);
    chk("old_val", int'(o__old_val), e_old);
    chk("new_val", int'(o__new_val), e_new);
`ifdef RAW_SAT_EN
    chk("sat", int'(o__sat), e_sat);
`endif
  end
  task automatic cyc(input int v, input int idx, input int op, input int val, input int clr);
    i__valid = v[0];
    i__idx = idx[1:0];
    i__op = op[1:0];
    i__write_val = val[2:0];
    i__clear = clr[0];
    @(posedge clk);
    model_step();
    #2;
  endtask
  task automatic lit(input string nm, input int v, input int o, input int n);
    chk({nm, "_v"}, int'(o__valid), v);
    chk({nm, "_old"}, int'(o__old_val), o);
    chk({nm, "_new"}, int'(o__new_val), n);
    chk({nm, "_mdl_old"}, e_old, o);
    chk({nm, "_mdl_new"}, e_new, n);
  endtask
  initial begin
    rst = 1'b1;
    i__valid = 0; i__idx = 0; i__op = 0; i__write_val = 0; i__clear = 0;
    model_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0);
      lit("idle", 0, 0, 0);
    end
    cyc(1, 1, 1, 5, 0);
    cyc(0, 0, 0, 0, 0);
    lit("wr", 1, 0, 5);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    lit("rd", 1, 5, 5);
    cyc(1, 2, 2, 3, 0);
    cyc(1, 2, 2, 3, 0);
    lit("b2b0", 1, 0, 3);
    cyc(1, 2, 2, 3, 0);
    lit("b2b1", 1, 3, 6);
    cyc(0, 0, 0, 0, 0);
`ifdef RAW_SAT_EN
    lit("b2b2", 1, 6, 7);
    chk("b2b2_sat", int'(o__sat), 1);
`else
    lit("b2b2", 1, 6, 1);
`endif
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 2, 1, 0);
    cyc(1, 3, 2, 2, 0);
    lit("il0", 1, 0, 1);
    cyc(1, 0, 2, 1, 0);
    lit("il1", 1, 0, 2);
    cyc(0, 0, 0, 0, 0);
    lit("il2", 1, 1, 2);
    cyc(1, 0, 1, 4, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 2, 2, 0);
    cyc(0, 0, 0, 0, 1);
    lit("clr0", 1, 4, 6);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    lit("clr1", 1, 0, 0);
    cyc(1, 1, 1, 3, 0);
    i__valid = 1'b1; i__idx = 2'd2; i__op = 2'd1; i__write_val = 3'd4;
    #1 rst = 1'b1;
    model_reset();
    #1 lit("rst_mid", 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1, k, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    lit("rst_rd3", 1, 0, 0);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b1;
        model_reset();
        #1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
      end
      cyc(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 15) == 0) ? 1 : 0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_state_raw.md
Name: pkt_state_raw

Overview:
- Stateful read-add-write stage downstream of the write-value mux stage (constant-vs-packet select).
- Consumes the selected write value plus a packet-carried state index and opcode.
- Performs a read-modify-write on a small per-index state array.
- Returns the pre-update and post-update state values to the packet pipeline after a fixed 2-cycle latency, with same-index forwarding so back-to-back packets see each other's updates.

Parameters:
COUNT_WIDTH, 3, width of state entries and of the write value
IDX_WIDTH, 2, state index width; array depth = 2**IDX_WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
i__valid  input  1  packet present this cycle
i__idx  input  IDX_WIDTH  state entry selected by packet
i__op  input  2  00 read-only, 01 write (replace), 10 add, 11 reserved (treated as read-only)
i__write_val  input  COUNT_WIDTH  operand from the upstream write mux
i__clear  input  1  synchronous clear of the whole state array
o__valid  output  1  result present
o__old_val  output  COUNT_WIDTH  entry value before this packet's update
o__new_val  output  COUNT_WIDTH  entry value after this packet's update

Behaviour:
- Reset (async, rst=1): all state entries = 0, both pipeline valid bits = 0, o__valid = 0, o__old_val = 0, o__new_val = 0. Reset mid-operation discards in-flight packets; no partial update is committed.
- Stage 1 (cycle N, i__valid=1): register idx, op and write_val; read array[idx] combinationally and register it as old.
- Stage 2 (cycle N+1):
  - compute new = old for read-only/reserved, new = write_val for write, new = old + write_val for add, truncated to COUNT_WIDTH (wrap modulo 2**COUNT_WIDTH).
  - Commit new to array[idx] at the end of N+1 when op is write or add.
- Outputs registered: o__valid/o__old_val/o__new_val valid at cycle N+2. Latency 2; throughput 1 packet/cycle; no backpressure.
- o__old_val/o__new_val hold their last values while o__valid=0.
- Forwarding: if the stage-1 packet's idx equals the stage-2 packet's idx and stage 2 is valid, stage 1 takes old = stage-2 new instead of the array value. Result equals strict in-order sequential execution.
- Back-to-back packets to different indices are independent.
- i__clear=1: at that edge all entries become 0.
  - The stage-2 commit in the same cycle is dropped (clear wins).
  - In-flight packets still produce outputs using their already-captured old values.
  - A packet entering stage 1 in the clear cycle reads the pre-clear value.
  - Forwarding is suppressed for the cycle after a clear; the next stage-1 read returns 0.
- i__valid=0: no state change except clear; pipeline valid bits shift in 0.

Optional Feature:
- Macro RAW_SAT_EN.
- Defined: add saturates at 2**COUNT_WIDTH-1 instead of wrapping; an additional output o__sat (1 bit, reset 0) is asserted alongside o__valid when saturation clipped the result.
- Undefined: add wraps modulo 2**COUNT_WIDTH; no o__sat port.

Test Plan:
- Reset then idle: rst pulse, i__valid=0 for 5 cycles -> o__valid=0, o__old_val=0, o__new_val=0 throughout.
- Write then read: write val=5 to idx 1 at cycle 0, read idx 1 at cycle 3 -> outputs at cycle 2 old=0,new=5; at cycle 5 old=5,new=5.
- Back-to-back add forwarding: idx 2 add 3 at cycles 0,1,2 -> outputs at cycles 2,3,4: (0,3),(3,6),(6,1 wrap at width 3); with RAW_SAT_EN the third is (6,7) with o__sat=1.
- Interleaved indices: add 1 to idx 0, add 2 to idx 3, add 1 to idx 0 consecutively -> (0,1),(0,2),(1,2); no cross-index corruption.
- Clear collision: idx 0 holds 4, add 2 at cycle 0, i__clear at cycle 1, read idx 0 at cycle 2 -> cycle 2 output (4,6); cycle 4 output (0,0).
- Async reset mid-flight: writes in cycles 0,1, rst asserted mid-cycle 1 -> outputs immediately 0; no o__valid pulse; all entries read 0 afterwards.
